control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control unit: 3-step fetch, then per-opcode execute steps T3..T6.
// Strobes are Moore-decoded from the present step and the IR opcode.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        LOin,
    output logic        HIin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [3:0]  alu_op,
    output logic [3:0]  state,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        C_BIN,
        C_UN,
        C_MD,
        C_HLT,
        C_ILL
    } op_class_t;

    state_t    cur;
    state_t    nxt;
    state_t    fin;
    op_class_t cls;
    logic [3:0] code;
    logic       unused_ir;

    assign unused_ir = ^IR[26:0];
    assign state     = cur;
    assign fin       = stop ? S_HALT : S_T0;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) cur <= S_IDLE;
        else        cur <= nxt;
    end

    always_comb begin
        cls  = C_ILL;
        code = 4'b0000;
        case (IR[31:27])
            5'b00011: begin cls = C_BIN; code = 4'b0001; end
            5'b00100: begin cls = C_BIN; code = 4'b0010; end
            5'b00101: begin cls = C_BIN; code = 4'b0011; end
            5'b00110: begin cls = C_BIN; code = 4'b0100; end
            5'b00111: begin cls = C_BIN; code = 4'b0101; end
            5'b01000: begin cls = C_BIN; code = 4'b0110; end
            5'b01001: begin cls = C_BIN; code = 4'b0111; end
            5'b01010: begin cls = C_BIN; code = 4'b1000; end
            5'b01011: begin cls = C_BIN; code = 4'b1001; end
            5'b01111: begin cls = C_MD;  code = 4'b1010; end
            5'b10000: begin cls = C_MD;  code = 4'b1011; end
            5'b10001: begin cls = C_UN;  code = 4'b1100; end
            5'b10010: begin cls = C_UN;  code = 4'b1101; end
            5'b11011: cls = C_HLT;
            default:  cls = C_ILL;
        endcase
    end

    always_comb begin
        nxt      = cur;
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        alu_op   = 4'b0000;
        halted   = 1'b0;
        illegal  = 1'b0;
        unique case (cur)
            S_IDLE: if (start) nxt = S_T0;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1;
                IncPC = 1'b1; Zin   = 1'b1;
                nxt   = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin  = 1'b1;
                Read    = 1'b1; MDRin = 1'b1;
                nxt     = S_T2;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                nxt    = S_T3;
            end
            S_T3: begin
                case (cls)
                    C_BIN: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                        nxt = S_T4;
                    end
                    C_UN: begin
                        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
                        alu_op = code;
                        nxt = S_T4;
                    end
                    C_MD: begin
                        Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                        nxt = S_T4;
                    end
                    C_HLT:   nxt = S_HALT;
                    default: begin
                        illegal = 1'b1;
                        nxt     = fin;
                    end
                endcase
            end
            S_T4: begin
                case (cls)
                    C_BIN, C_MD: begin
                        Grc  = (cls == C_BIN);
                        Grb  = (cls == C_MD);
                        Rout = 1'b1; Zin = 1'b1;
                        alu_op = code;
                        nxt  = S_T5;
                    end
                    C_UN: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        nxt = fin;
                    end
                    default: nxt = fin;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_BIN: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        nxt = fin;
                    end
                    C_MD: begin
                        Zlowout = 1'b1; LOin = 1'b1;
                        nxt = S_T6;
                    end
                    default: nxt = fin;
                endcase
            end
            S_T6: begin
                // IR changing mid-instruction is undefined; always retire here
                if (cls == C_MD) begin
                    Zhighout = 1'b1; HIin = 1'b1;
                end
                nxt = fin;
            end
            S_HALT: halted = 1'b1;
            default: nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with an expected-step scoreboard.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic        stop;
    logic [31:0] IR;
    logic        PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin;
    logic        Read, MDRin, MDRout, IRin, Yin, LOin, HIin;
    logic        Gra, Grb, Grc, Rin, Rout;
    logic [3:0]  alu_op;
    logic [3:0]  state;
    logic        halted;
    logic        illegal;

    control_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .stop(stop), .IR(IR),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .LOin(LOin), .HIin(HIin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .state(state),
        .halted(halted), .illegal(illegal)
    );

    always #5 clock = ~clock;

    localparam logic [18:0] K_PCOUT = 19'h40000;
    localparam logic [18:0] K_MARIN = 19'h20000;
    localparam logic [18:0] K_INCPC = 19'h10000;
    localparam logic [18:0] K_ZIN   = 19'h08000;
    localparam logic [18:0] K_ZLOW  = 19'h04000;
    localparam logic [18:0] K_ZHIGH = 19'h02000;
    localparam logic [18:0] K_PCIN  = 19'h01000;
    localparam logic [18:0] K_READ  = 19'h00800;
    localparam logic [18:0] K_MDRIN = 19'h00400;
    localparam logic [18:0] K_MDROUT= 19'h00200;
    localparam logic [18:0] K_IRIN  = 19'h00100;
    localparam logic [18:0] K_YIN   = 19'h00080;
    localparam logic [18:0] K_LOIN  = 19'h00040;
    localparam logic [18:0] K_HIIN  = 19'h00020;
    localparam logic [18:0] K_GRA   = 19'h00010;
    localparam logic [18:0] K_GRB   = 19'h00008;
    localparam logic [18:0] K_GRC   = 19'h00004;
    localparam logic [18:0] K_RIN   = 19'h00002;
    localparam logic [18:0] K_ROUT  = 19'h00001;

    localparam logic [31:0] I_ADD  = 32'h1A2B0000;
    localparam logic [31:0] I_MUL  = 32'h78000000;
    localparam logic [31:0] I_NEG  = 32'h88000000;
    localparam logic [31:0] I_HALT = 32'hD8000000;
    localparam logic [31:0] I_BAD  = 32'hF8000000;

    logic [18:0] sb;
    assign sb = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
                 Read, MDRin, MDRout, IRin, Yin, LOin, HIin,
                 Gra, Grb, Grc, Rin, Rout};

    typedef struct packed {
        logic [3:0]  st;
        logic [18:0] sb;
        logic [3:0]  alu;
        logic        hlt;
        logic        ill;
    } snap_t;

    snap_t q[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    task automatic push(input logic [3:0] st, input logic [18:0] s,
                        input logic [3:0] alu, input logic h,
                        input logic il);
        snap_t e;
        e.st = st; e.sb = s; e.alu = alu; e.hlt = h; e.ill = il;
        q.push_back(e);
    endtask

    task automatic push_fetch();
        push(4'd1, K_PCOUT | K_MARIN | K_INCPC | K_ZIN, 4'd0, 1'b0, 1'b0);
        push(4'd2, K_ZLOW | K_PCIN | K_READ | K_MDRIN, 4'd0, 1'b0, 1'b0);
        push(4'd3, K_MDROUT | K_IRIN, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic check_now(input string tag);
        snap_t e;
        n_assert++;
        if (q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, state got %0d", tag, state);
        end else begin
            e = q.pop_front();
            assert (state === e.st) else begin
                n_fail++;
                $error("FAIL %s state got %0d want %0d", tag, state, e.st);
            end
            n_assert++;
            assert (sb === e.sb) else begin
                n_fail++;
                $error("FAIL %s strobes got %h want %h", tag, sb, e.sb);
            end
            n_assert++;
            assert (alu_op === e.alu) else begin
                n_fail++;
                $error("FAIL %s alu_op got %b want %b", tag, alu_op, e.alu);
            end
            n_assert++;
            assert (halted === e.hlt) else begin
                n_fail++;
                $error("FAIL %s halted got %b want %b", tag, halted, e.hlt);
            end
            n_assert++;
            assert (illegal === e.ill) else begin
                n_fail++;
                $error("FAIL %s illegal got %b want %b", tag, illegal, e.ill);
            end
        end
    endtask

    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check_now(tag);
        end
    endtask

    initial begin
        clear = 1'b0;
        start = 1'b1;
        stop  = 1'b0;
        IR    = 32'h0;

        // reset held: start must not matter
        push(4'd0, 19'h0, 4'd0, 1'b0, 1'b0);
        push(4'd0, 19'h0, 4'd0, 1'b0, 1'b0);
        drain(2, "reset");
        clear = 1'b1;
        start = 1'b0;
        push(4'd0, 19'h0, 4'd0, 1'b0, 1'b0);
        push(4'd0, 19'h0, 4'd0, 1'b0, 1'b0);
        drain(2, "idle_wait");

        // ADD; IR garbage during fetch, stop=1 in non-final steps
        start = 1'b1;
        stop  = 1'b1;
        IR    = 32'hFFFFFFFF;
        push_fetch();
        drain(1, "add_t0");
        start = 1'b0;
        drain(1, "add_t1");
        IR = I_ADD;
        push(4'd4, K_GRB | K_ROUT | K_YIN, 4'd0, 1'b0, 1'b0);
        push(4'd5, K_GRC | K_ROUT | K_ZIN, 4'b0001, 1'b0, 1'b0);
        drain(3, "add_t2_t4");
        stop = 1'b0;
        push(4'd6, K_ZLOW | K_GRA | K_RIN, 4'd0, 1'b0, 1'b0);
        push_fetch();
        push(4'd4, K_GRB | K_ROUT | K_YIN, 4'd0, 1'b0, 1'b0);
        push(4'd5, K_GRC | K_ROUT | K_ZIN, 4'b0001, 1'b0, 1'b0);
        drain(6, "add_loop");

        // clear mid-T4: immediate return to IDLE without a clock edge
        #1 clear = 1'b0;
        #1;
        push(4'd0, 19'h0, 4'd0, 1'b0, 1'b0);
        check_now("async_clear");
        push(4'd0, 19'h0, 4'd0, 1'b0, 1'b0);
        drain(1, "clear_hold");
        clear = 1'b1;
        push(4'd0, 19'h0, 4'd0, 1'b0, 1'b0);
        drain(1, "post_clear_idle");

        // MUL, then NEG, then undefined, chained via stop=0
        start = 1'b1;
        IR    = I_MUL;
        push_fetch();
        push(4'd4, K_GRA | K_ROUT | K_YIN, 4'd0, 1'b0, 1'b0);
        push(4'd5, K_GRB | K_ROUT | K_ZIN, 4'b1010, 1'b0, 1'b0);
        push(4'd6, K_ZLOW | K_LOIN, 4'd0, 1'b0, 1'b0);
        push(4'd7, K_ZHIGH | K_HIIN, 4'd0, 1'b0, 1'b0);
        push(4'd1, K_PCOUT | K_MARIN | K_INCPC | K_ZIN, 4'd0, 1'b0, 1'b0);
        drain(1, "mul_t0");
        start = 1'b0;
        drain(7, "mul");
        IR = I_NEG;
        push(4'd2, K_ZLOW | K_PCIN | K_READ | K_MDRIN, 4'd0, 1'b0, 1'b0);
        push(4'd3, K_MDROUT | K_IRIN, 4'd0, 1'b0, 1'b0);
        push(4'd4, K_GRB | K_ROUT | K_ZIN, 4'b1100, 1'b0, 1'b0);
        push(4'd5, K_ZLOW | K_GRA | K_RIN, 4'd0, 1'b0, 1'b0);
        push(4'd1, K_PCOUT | K_MARIN | K_INCPC | K_ZIN, 4'd0, 1'b0, 1'b0);
        drain(5, "neg");
        IR = I_BAD;
        push(4'd2, K_ZLOW | K_PCIN | K_READ | K_MDRIN, 4'd0, 1'b0, 1'b0);
        push(4'd3, K_MDROUT | K_IRIN, 4'd0, 1'b0, 1'b0);
        push(4'd4, 19'h0, 4'd0, 1'b0, 1'b1);
        push(4'd1, K_PCOUT | K_MARIN | K_INCPC | K_ZIN, 4'd0, 1'b0, 1'b0);
        drain(4, "undef");

        // ADD with stop=1 at T5 -> HALT, start ignored there
        IR   = I_ADD;
        stop = 1'b1;
        push(4'd2, K_ZLOW | K_PCIN | K_READ | K_MDRIN, 4'd0, 1'b0, 1'b0);
        push(4'd3, K_MDROUT | K_IRIN, 4'd0, 1'b0, 1'b0);
        push(4'd4, K_GRB | K_ROUT | K_YIN, 4'd0, 1'b0, 1'b0);
        push(4'd5, K_GRC | K_ROUT | K_ZIN, 4'b0001, 1'b0, 1'b0);
        push(4'd6, K_ZLOW | K_GRA | K_RIN, 4'd0, 1'b0, 1'b0);
        push(4'd8, 19'h0, 4'd0, 1'b1, 1'b0);
        drain(6, "add_stop");
        start = 1'b1;
        stop  = 1'b0;
        push(4'd8, 19'h0, 4'd0, 1'b1, 1'b0);
        push(4'd8, 19'h0, 4'd0, 1'b1, 1'b0);
        drain(2, "halt_hold");
        start = 1'b0;
        clear = 1'b0;
        #1;
        push(4'd0, 19'h0, 4'd0, 1'b0, 1'b0);
        check_now("halt_clear");
        @(negedge clock);
        clear = 1'b1;

        // HALT opcode: T3 then HALT regardless of stop=0
        start = 1'b1;
        IR    = I_HALT;
        push_fetch();
        push(4'd4, 19'h0, 4'd0, 1'b0, 1'b0);
        push(4'd8, 19'h0, 4'd0, 1'b1, 1'b0);
        drain(1, "hlt_t0");
        start = 1'b0;
        drain(4, "hlt_op");
        start = 1'b1;
        push(4'd8, 19'h0, 4'd0, 1'b1, 1'b0);
        drain(1, "hlt_start");
        start = 1'b0;
        push(4'd8, 19'h0, 4'd0, 1'b1, 1'b0);
        drain(1, "hlt_stay");
        clear = 1'b0;
        #1;
        push(4'd0, 19'h0, 4'd0, 1'b0, 1'b0);
        check_now("hlt_op_clear");
        @(negedge clock);
        clear = 1'b1;
        push(4'd0, 19'h0, 4'd0, 1'b0, 1'b0);
        drain(1, "final_idle");

        n_assert++;
        assert (q.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_empty left %0d want 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
